// File: rtl/fc_neuron_mac_if.sv
// fc_neuron_mac_if
//
// Purpose: bundles every non-clock signal of the fully-connected neuron
// sequencer so the block and its environment connect through one port.
// The signal names match the neuron's pin names.
//
// Port summary (signal groups carried by the interface):
//   start, bias                   neuron kick-off and its signed bias
//   in_valid/in_ready/in_x/in_w   (activation, weight) pair stream
//   mul_enable/mul_reset/mul_m/mul_r/mul_result/mul_finish
//                                 Booth multiplier control and product
//   out_valid/out_ready/out_data  neuron result stream
//   busy                          neuron is not idle
//
// Modports:
//   master  environment side (pair source, multiplier, result sink)
//   slave   neuron side (fc_neuron_mac)
interface fc_neuron_mac_if #(
    parameter int N = 5
);
    logic                  start;
    logic signed [N-1:0]   bias;

    logic                  in_valid;
    logic                  in_ready;
    logic signed [N-1:0]   in_x;
    logic signed [N-1:0]   in_w;

    logic                  mul_enable;
    logic                  mul_reset;
    logic signed [N-1:0]   mul_m;
    logic signed [N-1:0]   mul_r;
    logic signed [2*N-1:0] mul_result;
    logic                  mul_finish;

    logic                  out_valid;
    logic                  out_ready;
    logic signed [N-1:0]   out_data;

    logic                  busy;

    modport master (
        output start, bias,
        output in_valid, in_x, in_w,
        input  in_ready,
        input  mul_enable, mul_reset, mul_m, mul_r,
        output mul_result, mul_finish,
        input  out_valid, out_data,
        output out_ready,
        input  busy
    );

    modport slave (
        input  start, bias,
        input  in_valid, in_x, in_w,
        output in_ready,
        output mul_enable, mul_reset, mul_m, mul_r,
        input  mul_result, mul_finish,
        output out_valid, out_data,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac
//
// Purpose: sequencing and accumulation stage for one fully-connected
// neuron wrapped around the FC Booth multiplier. For each neuron it
// captures a bias, pulls K (activation, weight) pairs, runs every pair
// through the multiplier's enable/reset/finish protocol, accumulates the
// signed products on top of the pre-scaled bias, then rescales,
// saturates and optionally ReLU-clamps the sum to N bits and offers the
// result on a valid/ready handshake.
//
// Parameters:
//   N      operand/result width (signed), equal to the multiplier's N, >= 3
//   K      pairs per neuron, >= 1
//   FRAC   fractional bits: bias pre-shift and final arithmetic right shift
//   ACC_W  accumulator width, >= 2N + clog2(K) + 1
//   RELU   1 clamps negative results to 0
//
// Ports:
//   clk    clock, everything on the rising edge
//   reset  synchronous active-high reset, returns to IDLE from any state
//   bus    fc_neuron_mac_if.slave: start/bias, pair stream, multiplier
//          control and product, result stream, busy
module fc_neuron_mac #(
    parameter int N     = 5,
    parameter int K     = 4,
    parameter int FRAC  = 2,
    parameter int ACC_W = 16,
    parameter int RELU  = 0
) (
    input  logic           clk,
    input  logic           reset,
    fc_neuron_mac_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    localparam int                  CNT_W    = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(K - 1);

    // The multiplier cannot negate the most negative operand, so that
    // weight is nudged one step towards zero before it is issued.
    localparam logic signed [N-1:0] W_MIN    = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] W_CLAMP  = {1'b1, {(N-2){1'b0}}, 1'b1};

    // Saturation limits of the N-bit result, sign-extended to ACC_W.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic [2:0]               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [N-1:0]      x_q, x_d;
    logic signed [N-1:0]      w_q, w_d;
    logic signed [N-1:0]      out_q, out_d;

    logic signed [ACC_W-1:0]  biasExt;
    logic signed [ACC_W-1:0]  prodExt;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [N-1:0]      satData;

    assign biasExt = {{(ACC_W-N){bus.bias[N-1]}}, bus.bias};
    assign prodExt = {{(ACC_W-2*N){bus.mul_result[2*N-1]}}, bus.mul_result};
    assign scaled  = acc_q >>> FRAC;

    // Rescaled sum folded into N bits: clip to the representable range
    // first, then the optional ReLU forces any negative sum to zero.
    always_comb begin
        satData = scaled[N-1:0];
        if (scaled > SAT_MAX) begin
            satData = SAT_MAX[N-1:0];
        end else if (scaled < SAT_MIN) begin
            satData = SAT_MIN[N-1:0];
        end
        if ((RELU != 0) && scaled[ACC_W-1]) begin
            satData = '0;
        end
    end

    // Neuron sequencer. WAIT is left only on mul_finish, so the block
    // tolerates any multiplier latency. The pair counter is tested before
    // it increments, so the K-th product moves straight on to FINAL.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        w_d     = w_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = biasExt <<< FRAC;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_x;
                    w_d     = (bus.in_w == W_MIN) ? W_CLAMP : bus.in_w;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mul_finish) begin
                    acc_d   = acc_q + prodExt;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_LAST) ? S_FINAL : S_FETCH;
                end
            end
            S_FINAL: begin
                out_d   = satData;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            w_q     <= w_d;
            out_q   <= out_d;
        end
    end

    // The multiplier is enabled for the whole load-plus-compute window;
    // its reset input acts as the one-cycle operand load strobe.
    assign bus.in_ready   = (state_q == S_FETCH);
    assign bus.mul_enable = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign bus.mul_reset  = (state_q == S_ISSUE);
    assign bus.mul_m      = w_q;
    assign bus.mul_r      = x_q;
    assign bus.out_valid  = (state_q == S_OUT);
    assign bus.out_data   = out_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fc_neuron_mac.sv
// tb_fc_neuron_mac
//
// Purpose: self-checking bench for fc_neuron_mac. Two neurons run in
// lock-step on the same stimulus, one with RELU=0 and one with RELU=1,
// sharing a behavioural Booth multiplier that raises finish N+1 cycles
// after each load. Directed vectors carry hand-computed results; the
// driver queues the expected results and operands, and an independent
// monitor pops and compares them whenever the neurons present a result
// or load the multiplier.
module tb_fc_neuron_mac;

    localparam int N     = 5;
    localparam int K     = 4;
    localparam int FRAC  = 2;
    localparam int ACC_W = 16;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fc_neuron_mac_if #(.N(N)) busA ();
    fc_neuron_mac_if #(.N(N)) busB ();

    fc_neuron_mac #(.N(N), .K(K), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(0)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    fc_neuron_mac #(.N(N), .K(K), .FRAC(FRAC), .ACC_W(ACC_W), .RELU(1)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    // The RELU neuron sees exactly the same inputs as the plain one.
    assign busB.start      = busA.start;
    assign busB.bias       = busA.bias;
    assign busB.in_valid   = busA.in_valid;
    assign busB.in_x       = busA.in_x;
    assign busB.in_w       = busA.in_w;
    assign busB.mul_result = busA.mul_result;
    assign busB.mul_finish = busA.mul_finish;
    assign busB.out_ready  = busA.out_ready;

    // Behavioural multiplier: operands load while enable and reset are
    // both high, the product is flagged with finish N+1 cycles later.
    logic                  mulBusy;
    int                    mulCnt;
    logic signed [2*N-1:0] mulProd;

    always @(posedge clk) begin
        if (reset) begin
            mulBusy <= 1'b0;
            mulCnt  <= 0;
            mulProd <= '0;
        end else if (busA.mul_enable && busA.mul_reset) begin
            mulBusy <= 1'b1;
            mulCnt  <= N;
            mulProd <= busA.mul_m * busA.mul_r;
        end else if (mulBusy) begin
            if (mulCnt == 0) begin
                mulBusy <= 1'b0;
            end else begin
                mulCnt <= mulCnt - 1;
            end
        end
    end

    assign busA.mul_finish = mulBusy && (mulCnt == 0) && busA.mul_enable;
    assign busA.mul_result = mulProd;

    int cycleCnt = 0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic signed [N-1:0] dataA;
        logic signed [N-1:0] dataB;
        int                  lat;
    } outExp_t;

    typedef struct {
        logic signed [N-1:0] m;
        logic signed [N-1:0] r;
    } pairExp_t;

    outExp_t  outQ[$];
    pairExp_t pairQ[$];

    int checks = 0;
    int errors = 0;
    int startCycle = 0;

    logic signed [N-1:0] vecX[K];
    logic signed [N-1:0] vecW[K];
    logic signed [N-1:0] vecM[K];

    function automatic logic signed [N-1:0] v(input int val);
        return val[N-1:0];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic finishBench();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " in_ready"},   busA.in_ready,   0);
        checkOutput({tag, " out_valid"},  busA.out_valid,  0);
        checkOutput({tag, " out_data"},   busA.out_data,   0);
        checkOutput({tag, " busy"},       busA.busy,       0);
        checkOutput({tag, " mul_enable"}, busA.mul_enable, 0);
        checkOutput({tag, " mul_reset"},  busA.mul_reset,  0);
        checkOutput({tag, " mul_m"},      busA.mul_m,      0);
        checkOutput({tag, " mul_r"},      busA.mul_r,      0);
        checkOutput({tag, " relu out_data"}, busB.out_data, 0);
        checkOutput({tag, " relu busy"},     busB.busy,     0);
    endtask

    // Runs one neuron with the pairs in vecX/vecW. stallPair drops
    // in_valid for three FETCH cycles before that pair, holdCycles keeps
    // out_ready low once the result shows, abortPair pulses start and
    // then reset during that pair's WAIT, startOnAccept raises start in
    // the same cycle the result is accepted.
    task automatic applyStimulus(input logic signed [N-1:0] b,
                                 input logic signed [N-1:0] expA,
                                 input logic signed [N-1:0] expB,
                                 input int lat, input int stallPair,
                                 input int holdCycles, input int abortPair,
                                 input bit startOnAccept);
        outExp_t  oe;
        pairExp_t pe;
        int       guard;

        busA.out_ready = (holdCycles > 0) ? 1'b0 : 1'b1;
        oe.dataA = expA;
        oe.dataB = expB;
        oe.lat   = lat;
        outQ.push_back(oe);
        busA.bias  = b;
        busA.start = 1'b1;
        startCycle = cycleCnt;
        @(negedge clk);
        busA.start = 1'b0;

        for (int p = 0; p < K; p++) begin
            if (p == stallPair) begin
                busA.in_valid = 1'b0;
                guard = 0;
                while (!busA.in_ready && guard < LIMIT) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= LIMIT) begin
                    checkOutput("stall in_ready timeout", 0, 1);
                    finishBench();
                end
                for (int s = 0; s < 3; s++) begin
                    checkOutput("stall in_ready",   busA.in_ready,   1);
                    checkOutput("stall mul_reset",  busA.mul_reset,  0);
                    checkOutput("stall mul_enable", busA.mul_enable, 0);
                    @(negedge clk);
                end
            end
            busA.in_valid = 1'b1;
            busA.in_x     = vecX[p];
            busA.in_w     = vecW[p];
            pe.m = vecM[p];
            pe.r = vecX[p];
            pairQ.push_back(pe);
            guard = 0;
            while (!busA.in_ready && guard < LIMIT) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= LIMIT) begin
                checkOutput("pair accept timeout", 0, 1);
                finishBench();
            end
            @(negedge clk);
            if (p == abortPair) begin
                busA.in_valid = 1'b0;
                @(negedge clk);
                busA.start = 1'b1;
                busA.bias  = v(15);
                @(negedge clk);
                busA.start = 1'b0;
                checkOutput("ignored start busy",       busA.busy,       1);
                checkOutput("ignored start mul_enable", busA.mul_enable, 1);
                checkOutput("ignored start in_ready",   busA.in_ready,   0);
                reset = 1'b1;
                @(negedge clk);
                checkAllZero("mid-run reset");
                reset = 1'b0;
                outQ.delete();
                pairQ.delete();
                @(negedge clk);
                return;
            end
        end
        busA.in_valid = 1'b0;

        guard = 0;
        while (!busA.out_valid && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= LIMIT) begin
            checkOutput("out_valid timeout", 0, 1);
            finishBench();
        end
        for (int h = 0; h < holdCycles; h++) begin
            checkOutput("hold out_valid", busA.out_valid, 1);
            checkOutput("hold out_data",  busA.out_data,  expA);
            checkOutput("hold in_ready",  busA.in_ready,  0);
            checkOutput("hold busy",      busA.busy,      1);
            @(negedge clk);
        end
        busA.out_ready = 1'b1;
        if (startOnAccept) begin
            busA.start = 1'b1;
            busA.bias  = v(5);
        end
        @(negedge clk);
        busA.start = 1'b0;
        checkOutput("post accept busy",      busA.busy,      0);
        checkOutput("post accept out_valid", busA.out_valid, 0);
        @(negedge clk);
        checkOutput("idle after accept busy", busA.busy, 0);
    endtask

    // Monitor: checks operands at every multiplier load, the load pulse
    // width, and each result as it is first presented.
    outExp_t  oeMon;
    pairExp_t peMon;
    int       issueCnt     = 0;
    bit       prevMulReset = 1'b0;
    bit       prevValid    = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            issueCnt     = 0;
            prevMulReset = 1'b0;
            prevValid    = 1'b0;
        end else begin
            if (prevMulReset) begin
                checkOutput("mul_reset width", busA.mul_reset, 0);
            end
            if (busA.mul_reset) begin
                issueCnt++;
                checkOutput("load mul_enable", busA.mul_enable, 1);
                if (pairQ.size() == 0) begin
                    checkOutput("unexpected mul_reset", 1, 0);
                end else begin
                    peMon = pairQ.pop_front();
                    checkOutput("mul_m", busA.mul_m, peMon.m);
                    checkOutput("mul_r", busA.mul_r, peMon.r);
                end
            end
            if (busA.out_valid && !prevValid) begin
                if (outQ.size() == 0) begin
                    checkOutput("unexpected out_valid", 1, 0);
                end else begin
                    oeMon = outQ.pop_front();
                    checkOutput("out_data",         busA.out_data,  oeMon.dataA);
                    checkOutput("relu out_valid",   busB.out_valid, 1);
                    checkOutput("relu out_data",    busB.out_data,  oeMon.dataB);
                    checkOutput("out_valid cycle",  cycleCnt - startCycle, oeMon.lat);
                    checkOutput("mul_reset pulses", issueCnt, K);
                end
                issueCnt = 0;
            end
            if (!busA.busy) begin
                issueCnt = 0;
            end
            prevMulReset = busA.mul_reset;
            prevValid    = busA.out_valid;
        end
    end

    initial begin
        #200000;
        checkOutput("global timeout", 0, 1);
        finishBench();
    end

    initial begin
        reset          = 1'b1;
        busA.start     = 1'b0;
        busA.bias      = '0;
        busA.in_valid  = 1'b0;
        busA.in_x      = '0;
        busA.in_w      = '0;
        busA.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] nominal");
        vecX = '{v(3), v(2), v(-1), v(1)};
        vecW = '{v(3), v(3), v(2),  v(1)};
        vecM = '{v(3), v(3), v(2),  v(1)};
        applyStimulus(v(1), v(4), v(4), 34, -1, 0, -1, 1'b1);

        $display("[TB] positive saturation");
        vecX = '{v(15), v(15), v(15), v(15)};
        vecW = '{v(15), v(15), v(15), v(15)};
        vecM = '{v(15), v(15), v(15), v(15)};
        applyStimulus(v(15), v(15), v(15), 34, -1, 0, -1, 1'b0);

        $display("[TB] negative saturation");
        vecX = '{v(-16), v(-16), v(-16), v(-16)};
        vecW = '{v(15),  v(15),  v(15),  v(15)};
        vecM = '{v(15),  v(15),  v(15),  v(15)};
        applyStimulus(v(-16), v(-16), v(0), 34, -1, 0, -1, 1'b0);

        $display("[TB] weight clamp");
        vecX = '{v(4),   v(4),   v(4),   v(4)};
        vecW = '{v(-16), v(-16), v(-16), v(-16)};
        vecM = '{v(-15), v(-15), v(-15), v(-15)};
        applyStimulus(v(0), v(-16), v(0), 34, -1, 0, -1, 1'b0);

        $display("[TB] mixed signs, floor shift");
        vecX = '{v(2),  v(1), v(0), v(-1)};
        vecW = '{v(-3), v(1), v(5), v(1)};
        vecM = '{v(-3), v(1), v(5), v(1)};
        applyStimulus(v(-3), v(-5), v(0), 34, -1, 0, -1, 1'b0);

        $display("[TB] backpressure");
        vecX = '{v(3), v(2), v(-1), v(1)};
        vecW = '{v(3), v(3), v(2),  v(1)};
        vecM = '{v(3), v(3), v(2),  v(1)};
        applyStimulus(v(1), v(4), v(4), 37, 1, 5, -1, 1'b0);

        $display("[TB] abort by reset");
        applyStimulus(v(1), v(4), v(4), 34, -1, 0, 1, 1'b0);

        $display("[TB] nominal after abort");
        applyStimulus(v(1), v(4), v(4), 34, -1, 0, -1, 1'b0);

        repeat (4) @(negedge clk);
        checkOutput("results left over",  outQ.size(),  0);
        checkOutput("operands left over", pairQ.size(), 0);
        finishBench();
    end

endmodule
